rate_divider_prog: RTL

//  Programmable rate divider. Emits a one-cycle pulse every PERIOD enabled clock edges.
//  - Width is parametrised; continuous and one-shot modes; start/stop control.
//  - A new period can be queued while running and takes effect at the next wrap.
//  - Drives animation/tick timing for display and game-logic FSMs; one instance per timebase.
//

---
 rtl/rate_divider_prog_if.sv | 24 ++
 rtl/rate_divider_prog.sv | 60 ++++++
 2 files changed

// File: rtl/rate_divider_prog_if.sv
// rate_divider_prog_if: control and status bundle for the programmable rate divider
interface rate_divider_prog_if #(
  parameter int WIDTH  = 32,
  parameter int PCNT_W = 16
);
  logic              enable;
  logic              start;
  logic              stop;
  logic              one_shot;
  logic [WIDTH-1:0]  period_in;
  logic              period_load;
  logic              out_pulse;
  logic              busy;
  logic [WIDTH-1:0]  remaining;
  logic [PCNT_W-1:0] pulse_count;
  modport master (
    output enable, start, stop, one_shot, period_in, period_load,
    input  out_pulse, busy, remaining, pulse_count
  );
  modport slave (
    input  enable, start, stop, one_shot, period_in, period_load,
    output out_pulse, busy, remaining, pulse_count
  );
endinterface

// File: rtl/rate_divider_prog.sv
// rate_divider_prog: programmable down-counting rate divider with one-shot and queued reload
module rate_divider_prog #(
  parameter int WIDTH  = 32,
  parameter int PCNT_W = 16
) (
  input logic clock,
  input logic resetn,
  rate_divider_prog_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]       state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] pend;
  logic             mode;
  logic             start_ok;
  logic             run_en;
  logic             wrap;
  logic             load_ok;
  logic [WIDTH-1:0] next_pend;
  // stop beats start, and start beats any counting or reload in the same cycle
  always_comb begin
    start_ok  = bus.start && bus.period_in != '0;
    run_en    = state == RUN && bus.enable && !bus.stop && !start_ok;
    wrap      = run_en && count == '0;
    load_ok   = run_en && bus.period_load && bus.period_in != '0;
    next_pend = load_ok ? bus.period_in : pend;
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state           <= IDLE;
      count           <= '0;
      pend            <= '0;
      mode            <= 1'b0;
      bus.out_pulse   <= 1'b0;
      bus.pulse_count <= '0;
    end else begin
      bus.out_pulse <= wrap;
      if (bus.stop) begin
        state <= IDLE;
      end else if (start_ok) begin
        state <= RUN;
        count <= bus.period_in - 1'b1;
        pend  <= bus.period_in;
        mode  <= bus.one_shot;
      end else if (run_en) begin
        pend <= next_pend;
        if (count != '0) begin
          count <= count - 1'b1;
        end else begin
          bus.pulse_count <= bus.pulse_count + 1'b1;
          if (mode) state <= IDLE;
          else count <= next_pend - 1'b1;
        end
      end
    end
  end
  assign bus.busy      = state == RUN;
  assign bus.remaining = count;
endmodule
